// File: rtl/ramp_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ramp_sequencer_pkg
//   Shared definitions for the ramp sequencer slice: FSM state encoding and
//   counter direction codes. Imported by the counter and the sequencer.
// ---------------------------------------------------------------------------
package ramp_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/ramp_sequencer_counter.sv
// ---------------------------------------------------------------------------
// ramp_sequencer_counter
//   Saturating up/down counter. Counts one LSB per enabled cycle in the
//   direction given by CONTROL, clamping at 0 and at all-ones.
// Ports
//   CLOCK    in   1     rising-edge clock
//   RESET_N  in   1     asynchronous active-low reset (COUNT -> 0)
//   ENABLE   in   1     step this cycle
//   CONTROL  in   1     DIR_UP = count up, DIR_DOWN = count down
//   COUNT    out  SIZE  current value
// ---------------------------------------------------------------------------
module ramp_sequencer_counter
  import ramp_sequencer_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic            CLOCK,
  input  logic            RESET_N,
  input  logic            ENABLE,
  input  logic            CONTROL,
  output logic [SIZE-1:0] COUNT
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      COUNT <= '0;
    end else if (ENABLE) begin
      if (CONTROL == DIR_UP) begin
        if (COUNT != '1) COUNT <= COUNT + SIZE'(1);
      end else begin
        if (COUNT != '0) COUNT <= COUNT - SIZE'(1);
      end
    end
  end

endmodule

// File: rtl/ramp_sequencer.sv
// ---------------------------------------------------------------------------
// ramp_sequencer
//   Ramps the saturating counter from its current value to a commanded
//   target, one LSB per step, with a programmable dwell of D idle cycles
//   between steps (steps are D+1 cycles apart). Commands use valid/ready;
//   completion is a registered one-cycle DONE pulse. ABORT stops a ramp
//   with the count held and no DONE.
// Ports
//   CLOCK       in   1        rising-edge clock
//   RESET       in   1        asynchronous active-high reset
//   CMD_VALID   in   1        command present
//   CMD_READY   out  1        high only in IDLE
//   CMD_TARGET  in   SIZE     target count value
//   CMD_DWELL   in   DWELL_W  idle cycles between steps
//   ABORT       in   1        stop an active ramp (ignored in IDLE)
//   COUNT       out  SIZE     counter value
//   DIR         out  1        registered direction of the last step
//   BUSY        out  1        high while ramping
//   DONE        out  1        one-cycle pulse when the target is reached
// ---------------------------------------------------------------------------
module ramp_sequencer
  import ramp_sequencer_pkg::*;
#(
  parameter int SIZE    = 4,
  parameter int DWELL_W = 4
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [SIZE-1:0]    CMD_TARGET,
  input  logic [DWELL_W-1:0] CMD_DWELL,
  input  logic               ABORT,
  output logic [SIZE-1:0]    COUNT,
  output logic               DIR,
  output logic               BUSY,
  output logic               DONE
);

  state_t             state, state_next;
  logic [SIZE-1:0]    target;
  logic [DWELL_W-1:0] dwell;
  logic [DWELL_W-1:0] timer;
  logic               step_en;
  logic               control;
  logic               done_next;
  logic               accept;
  logic               at_target;

  assign CMD_READY = (state == ST_IDLE);
  assign BUSY      = (state == ST_RUN);
  assign accept    = CMD_VALID & CMD_READY;
  assign at_target = (COUNT == target);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    step_en    = 1'b0;
    done_next  = 1'b0;
    control    = (target > COUNT) ? DIR_UP : DIR_DOWN;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_RUN;
      end
      ST_RUN: begin
        // Completion has priority over ABORT in the same cycle.
        if (at_target) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else if (ABORT) begin
          state_next = ST_IDLE;
        end else if (timer == '0) begin
          step_en = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state  <= ST_IDLE;
      DONE   <= 1'b0;
      DIR    <= DIR_DOWN;
      target <= '0;
      dwell  <= '0;
      timer  <= '0;
    end else begin
      state <= state_next;
      DONE  <= done_next;
      if (step_en) DIR <= control;
      if (accept) begin
        target <= CMD_TARGET;
        dwell  <= CMD_DWELL;
      end
      // Timer reloads with the dwell on each step and counts down to zero;
      // the next step fires once it reaches zero.
      if (accept)                           timer <= '0;
      else if (step_en)                     timer <= dwell;
      else if (BUSY && (timer != '0))       timer <= timer - DWELL_W'(1);
    end
  end

  ramp_sequencer_counter #(
    .SIZE (SIZE)
  ) u_counter (
    .CLOCK   (CLOCK),
    .RESET_N (~RESET),
    .ENABLE  (step_en),
    .CONTROL (control),
    .COUNT   (COUNT)
  );

endmodule

// File: tb/tb_ramp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ramp_sequencer
//   Directed self-checking bench for ramp_sequencer. Inputs change and
//   outputs are sampled on the falling edge; each "cycle" below is one
//   falling edge, with the accept cycle of a command called c.
// ---------------------------------------------------------------------------
module tb_ramp_sequencer;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [3:0] CMD_TARGET;
  logic [3:0] CMD_DWELL;
  logic       ABORT;
  logic [3:0] COUNT;
  logic       DIR;
  logic       BUSY;
  logic       DONE;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLOCK = ~CLOCK;

  ramp_sequencer #(.SIZE(4), .DWELL_W(4)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .CMD_VALID  (CMD_VALID),
    .CMD_READY  (CMD_READY),
    .CMD_TARGET (CMD_TARGET),
    .CMD_DWELL  (CMD_DWELL),
    .ABORT      (ABORT),
    .COUNT      (COUNT),
    .DIR        (DIR),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK);
  endtask

  // Presents a command for one cycle (the accept cycle c); returns in c+1.
  task automatic send(input logic [3:0] t, input logic [3:0] d);
    check("ready_before_cmd", {7'd0, CMD_READY}, 8'd1);
    CMD_VALID  = 1'b1;
    CMD_TARGET = t;
    CMD_DWELL  = d;
    tick();
    CMD_VALID  = 1'b0;
  endtask

  initial begin
    RESET      = 1'b1;
    CMD_VALID  = 1'b0;
    CMD_TARGET = 4'd0;
    CMD_DWELL  = 4'd0;
    ABORT      = 1'b0;
    tick();
    tick();
    check("rst_count", {4'd0, COUNT}, 8'd0);
    check("rst_done",  {7'd0, DONE}, 8'd0);
    check("rst_busy",  {7'd0, BUSY}, 8'd0);
    check("rst_ready", {7'd0, CMD_READY}, 8'd1);
    check("rst_dir",   {7'd0, DIR}, 8'd0);
    RESET = 1'b0;
    tick();

    // 1. T=5 D=0 from 0: COUNT 1..5 in c+2..c+6, DONE in c+7.
    send(4'd5, 4'd0);
    check("t1_busy_c1",  {7'd0, BUSY}, 8'd1);
    check("t1_count_c1", {4'd0, COUNT}, 8'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t1_count", {4'd0, COUNT}, 8'(k));
      check("t1_dir",   {7'd0, DIR}, 8'd1);
      check("t1_nodone", {7'd0, DONE}, 8'd0);
    end
    tick();
    check("t1_done",  {7'd0, DONE}, 8'd1);
    check("t1_idle",  {7'd0, BUSY}, 8'd0);
    check("t1_final", {4'd0, COUNT}, 8'd5);
    tick();
    check("t1_done_pulse", {7'd0, DONE}, 8'd0);

    // 2. T=2 D=3 from 5: COUNT 4 @c+2, 3 @c+6, 2 @c+10, DONE @c+11.
    send(4'd2, 4'd3);
    for (int i = 2; i <= 10; i++) begin
      tick();
      check("t2_count", {4'd0, COUNT}, (i < 6) ? 8'd4 : (i < 10) ? 8'd3 : 8'd2);
      check("t2_nodone", {7'd0, DONE}, 8'd0);
    end
    check("t2_dir", {7'd0, DIR}, 8'd0);
    tick();
    check("t2_done", {7'd0, DONE}, 8'd1);

    // 3. T equal to COUNT: no step, DONE at c+2.
    tick();
    send(4'd2, 4'd7);
    check("t3_busy",   {7'd0, BUSY}, 8'd1);
    check("t3_nostep", {7'd0, dut.step_en}, 8'd0);
    tick();
    check("t3_done",  {7'd0, DONE}, 8'd1);
    check("t3_count", {4'd0, COUNT}, 8'd2);

    // Return to 0: COUNT 1 @c+2, 0 @c+3, DONE @c+4.
    send(4'd0, 4'd0);
    tick(); tick(); tick();
    check("t4_pre_done",  {7'd0, DONE}, 8'd1);
    check("t4_pre_count", {4'd0, COUNT}, 8'd0);

    // 4. T=15 D=0, pending command held from c+3, ABORT when COUNT=7 (c+8).
    send(4'd15, 4'd0);
    tick();
    tick();                       // c+3, COUNT=2
    CMD_VALID  = 1'b1;
    CMD_TARGET = 4'd9;
    CMD_DWELL  = 4'd0;
    for (int i = 3; i <= 7; i++) begin
      tick();                     // c+4..c+8
      check("t4_ramp", {4'd0, COUNT}, 8'(i));
      check("t4_held", {7'd0, CMD_READY}, 8'd0);
    end
    ABORT = 1'b1;
    tick();                       // c+9: aborted
    ABORT = 1'b0;
    check("t4_hold",   {4'd0, COUNT}, 8'd7);
    check("t4_ready",  {7'd0, CMD_READY}, 8'd1);
    check("t4_nodone", {7'd0, DONE}, 8'd0);
    tick();                       // pending command accepted in previous cycle
    CMD_VALID = 1'b0;
    check("t4_acc_busy",  {7'd0, BUSY}, 8'd1);
    check("t4_acc_count", {4'd0, COUNT}, 8'd7);
    tick();
    check("t4_c2", {4'd0, COUNT}, 8'd8);
    tick();
    check("t4_c3", {4'd0, COUNT}, 8'd9);
    tick();
    check("t4_done", {7'd0, DONE}, 8'd1);

    // 5. Reset mid-ramp at COUNT=9, T=12.
    send(4'd12, 4'd5);
    check("t5_pre", {4'd0, COUNT}, 8'd9);
    RESET = 1'b1;
    #1;
    check("t5_rst_count", {4'd0, COUNT}, 8'd0);
    check("t5_rst_busy",  {7'd0, BUSY}, 8'd0);
    check("t5_rst_done",  {7'd0, DONE}, 8'd0);
    check("t5_rst_ready", {7'd0, CMD_READY}, 8'd1);
    tick();
    RESET = 1'b0;
    tick();
    check("t5_post_count", {4'd0, COUNT}, 8'd0);
    check("t5_post_done",  {7'd0, DONE}, 8'd0);
    // T=3 D=1: COUNT 1 @c+2, 2 @c+4, 3 @c+6, DONE @c+7.
    send(4'd3, 4'd1);
    tick();
    check("t5_c2", {4'd0, COUNT}, 8'd1);
    tick();
    check("t5_c3", {4'd0, COUNT}, 8'd1);
    tick();
    check("t5_c4", {4'd0, COUNT}, 8'd2);
    tick(); tick();
    check("t5_c6", {4'd0, COUNT}, 8'd3);
    tick();
    check("t5_done", {7'd0, DONE}, 8'd1);

    // 6. Back-to-back: accept in the DONE cycle, second ramp T=1 starts next.
    send(4'd1, 4'd0);
    check("t6_busy",  {7'd0, BUSY}, 8'd1);
    check("t6_count", {4'd0, COUNT}, 8'd3);
    check("t6_done_drop", {7'd0, DONE}, 8'd0);
    tick();
    check("t6_c2",  {4'd0, COUNT}, 8'd2);
    check("t6_dir", {7'd0, DIR}, 8'd0);
    tick();
    check("t6_c3", {4'd0, COUNT}, 8'd1);
    tick();
    check("t6_done", {7'd0, DONE}, 8'd1);
    check("t6_idle", {7'd0, BUSY}, 8'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
